// File: rtl/euler_step_pkg.sv
// Shared Q-format constants, ring entry layout and saturation helper for the
// fixed-point forward-Euler step unit.
package euler_step_pkg;

  localparam int unsigned DW_DEF   = 32;
  localparam int unsigned FRAC_DEF = 24;
  localparam int unsigned SAT_W    = 128;

  localparam logic [63:0] ONE      = 64'(1) << FRAC_DEF;
  localparam logic [63:0] HALF_LSB = 64'(1) << (FRAC_DEF - 1);

  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic              sat;
  } ring_entry_t;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [SAT_W-1:0] saturate(
    input  logic signed [SAT_W-1:0] v,
    input  int unsigned             w,
    output logic                    sat
  );
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = SAT_W'((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    sat = 1'b0;
    saturate = v;
    if (v > hi) begin
      saturate = hi;
      sat = 1'b1;
    end else if (v < lo) begin
      saturate = lo;
      sat = 1'b1;
    end
  endfunction

endpackage

// File: rtl/euler_delay_ring.sv
// Programmable alignment delay: circular buffer with a separate valid-bit
// array, cleared whenever a new delay is loaded; delay 0 bypasses the buffer.
module euler_delay_ring #(
  parameter int unsigned WIDTH   = 99,
  parameter int unsigned DLY_MAX = 256,
  parameter int unsigned DLY_W   = $clog2(DLY_MAX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [DLY_W-1:0] dly,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout_c,
  output logic             dout_valid_c
);

  logic [WIDTH-1:0]   mem [DLY_MAX];
  logic [DLY_MAX-1:0] vld;
  logic [DLY_W-1:0]   wr_ptr;
  logic [DLY_W-1:0]   rd_idx;
  logic [DLY_W-1:0]   dly_active;

  assign rd_idx = wr_ptr - dly_active;

  // Pointer, valid bits and active delay; a reload discards all stale entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      vld        <= '0;
      dly_active <= dly;
    end else begin
      wr_ptr <= wr_ptr + DLY_W'(1);
      if (reload) begin
        vld        <= '0;
        dly_active <= dly;
      end else begin
        vld[wr_ptr] <= din_valid;
      end
    end
  end

  always_ff @(posedge clk) begin
    mem[wr_ptr] <= din;
  end

  always_comb begin
    dout_c       = din;
    dout_valid_c = din_valid;
    if (dly_active != '0) begin
      dout_c       = mem[rd_idx];
      dout_valid_c = vld[rd_idx];
    end
  end

endmodule

// File: rtl/euler_step_fx.sv
// NCH-channel fixed-point forward-Euler step x' = x + tau*dx with saturation
// and a programmable alignment delay. Define EULER_STEP_ROUND_EN for round-half-up.
module euler_step_fx
  import euler_step_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DW_DEF,
  parameter int unsigned FRAC_BITS  = FRAC_DEF,
  parameter int unsigned NCH        = 3,
  parameter int unsigned MUL_STAGES = 3,
  parameter int unsigned DLY_MAX    = 256,
  parameter int unsigned DLY_W      = $clog2(DLY_MAX)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     tau,
  input  logic [DLY_W-1:0]          dly,
  input  logic                      in_valid,
  input  logic [NCH*DATA_WIDTH-1:0] deriv,
  input  logic [NCH*DATA_WIDTH-1:0] state,
  output logic                      out_valid,
  output logic [NCH*DATA_WIDTH-1:0] state_next,
  output logic [NCH-1:0]            out_sat,
  output logic                      busy
);

  localparam int unsigned PW    = 2 * DATA_WIDTH;
  localparam int unsigned SW    = 2 * DATA_WIDTH - FRAC_BITS + 1;
  localparam int unsigned EW    = DATA_WIDTH + 1;
  localparam int unsigned RW    = NCH * EW;
  localparam int unsigned CNT_W = $clog2(DLY_MAX + MUL_STAGES + 3) + 1;
`ifdef EULER_STEP_ROUND_EN
  localparam logic signed [PW-1:0] HALF = PW'(1) << (FRAC_BITS - 1);
`endif

  logic signed [PW-1:0]         prod_q [MUL_STAGES][NCH];
  logic signed [DATA_WIDTH-1:0] st_q   [MUL_STAGES][NCH];
  logic [MUL_STAGES-1:0]        mv_q;

  logic signed [PW-1:0]    p_r     [NCH];
  logic signed [PW-1:0]    scaled  [NCH];
  logic signed [SW-1:0]    sum     [NCH];
  logic signed [SAT_W-1:0] clamped [NCH];
  logic [NCH-1:0]          sat_c;

  logic [RW-1:0]    add_q;
  logic             av_q;
  logic [RW-1:0]    ring_dout_c;
  logic             ring_valid_c;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             reload_c;

  // Multiply pipeline; state rides alongside the product.
  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NCH); k++) begin
      prod_q[0][k] <= PW'($signed(tau)) * PW'($signed(deriv[k*DATA_WIDTH +: DATA_WIDTH]));
      st_q[0][k]   <= state[k*DATA_WIDTH +: DATA_WIDTH];
    end
    for (int s = 1; s < int'(MUL_STAGES); s++) begin
      prod_q[s] <= prod_q[s-1];
      st_q[s]   <= st_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mv_q <= '0;
      av_q <= 1'b0;
    end else begin
      mv_q <= {mv_q, in_valid};
      av_q <= mv_q[MUL_STAGES-1];
    end
  end

  // Scale back to Q format, accumulate at full width, then clamp.
  always_comb begin
    for (int k = 0; k < int'(NCH); k++) begin
      p_r[k] = prod_q[MUL_STAGES-1][k];
`ifdef EULER_STEP_ROUND_EN
      p_r[k] = p_r[k] + HALF;
`endif
      scaled[k]  = p_r[k] >>> FRAC_BITS;
      sum[k]     = SW'(st_q[MUL_STAGES-1][k]) + SW'(scaled[k]);
      clamped[k] = saturate(SAT_W'(sum[k]), DATA_WIDTH, sat_c[k]);
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < int'(NCH); k++) begin
      add_q[k*EW +: EW] <= {DATA_WIDTH'(clamped[k]), sat_c[k]};
    end
  end

  assign reload_c = (cnt_q == '0) && !in_valid;

  euler_delay_ring #(
    .WIDTH   (RW),
    .DLY_MAX (DLY_MAX),
    .DLY_W   (DLY_W)
  ) u_ring (
    .clk          (clk),
    .rst          (rst),
    .reload       (reload_c),
    .dly          (dly),
    .din          (add_q),
    .din_valid    (av_q),
    .dout_c       (ring_dout_c),
    .dout_valid_c (ring_valid_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_sat    <= '0;
      state_next <= '0;
    end else begin
      out_valid <= ring_valid_c;
      out_sat   <= '0;
      if (ring_valid_c) begin
        for (int k = 0; k < int'(NCH); k++) begin
          state_next[k*DATA_WIDTH +: DATA_WIDTH] <= ring_dout_c[k*EW + 1 +: DATA_WIDTH];
          out_sat[k]                             <= ring_dout_c[k*EW];
        end
      end
    end
  end

  // In-flight accounting: accepted samples minus delivered samples.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(in_valid) - CNT_W'(out_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      busy  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      busy  <= (cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_euler_step_fx.sv
// Directed and model-based bench for euler_step_fx: Q8.24 corner vectors,
// delay ring across pointer wrap, mid-stream reset and a long continuous run.
module tb_euler_step_fx;
  import euler_step_pkg::*;

  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 3;
  localparam int unsigned DLW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [DW-1:0]   tau = '0;
  logic [DLW-1:0]  dly = '0;
  logic            in_valid = 1'b0;
  logic [NCH*DW-1:0] deriv = '0;
  logic [NCH*DW-1:0] state = '0;
  logic            out_valid;
  logic [NCH*DW-1:0] state_next;
  logic [NCH-1:0]  out_sat;
  logic            busy;

  euler_step_fx dut (
    .clk        (clk),
    .rst        (rst),
    .tau        (tau),
    .dly        (dly),
    .in_valid   (in_valid),
    .deriv      (deriv),
    .state      (state),
    .out_valid  (out_valid),
    .state_next (state_next),
    .out_sat    (out_sat),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    ring_entry_t [NCH-1:0] ch;
    int                    due;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic ring_entry_t model(input logic [31:0] t, input logic [31:0] d,
                                        input logic [31:0] s);
    longint      p;
    longint      sm;
    ring_entry_t r;
    p = longint'($signed(t)) * longint'($signed(d));
`ifdef EULER_STEP_ROUND_EN
    p = p + longint'(HALF_LSB);
`endif
    p  = p >>> FRAC_DEF;
    sm = longint'($signed(s)) + p;
    if (sm > longint'(32'sh7FFF_FFFF))      r = '{data: 32'h7FFF_FFFF, sat: 1'b1};
    else if (sm < longint'(32'sh8000_0000)) r = '{data: 32'h8000_0000, sat: 1'b1};
    else                                    r = '{data: 32'(sm), sat: 1'b0};
    return r;
  endfunction

  task automatic issue(input logic [31:0] t, input logic [95:0] d, input logic [95:0] s,
                       input ring_entry_t [NCH-1:0] e, input int lat);
    exp_t x;
    @(posedge clk);
    #1;
    tau = t; deriv = d; state = s; in_valid = 1'b1;
    x.ch = e;
    x.due = cyc + lat;
    q.push_back(x);
  endtask

  task automatic issue_model(input logic [31:0] t, input logic [95:0] d,
                             input logic [95:0] s, input int lat);
    ring_entry_t [NCH-1:0] e;
    for (int k = 0; k < int'(NCH); k++)
      e[k] = model(t, d[k*32 +: 32], s[k*32 +: 32]);
    issue(t, d, s, e, lat);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || busy) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_pending", 128'(q.size()), 128'(0));
    check("drain_busy", 128'(busy), 128'(0));
  endtask

  // Scoreboard: order, value, saturation, arrival cycle and busy flag.
  always @(negedge clk) begin
    exp_t e;
    logic [95:0] ed;
    logic [2:0]  es;
    if (!rst) begin
      check("busy", 128'(busy), 128'((int'(q.size()) - int'(in_valid)) != 0));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 128'(out_valid), 128'(0));
        end else begin
          e = q.pop_front();
          for (int k = 0; k < int'(NCH); k++) begin
            ed[k*32 +: 32] = e.ch[k].data;
            es[k]          = e.ch[k].sat;
          end
          check("state_next", 128'(state_next), 128'(ed));
          check("out_sat", 128'(out_sat), 128'(es));
          check("latency", 128'(cyc), 128'(e.due));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    ring_entry_t [NCH-1:0] e;
    logic [95:0] d;
    logic [95:0] s;
    logic [31:0] t;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_out_sat", 128'(out_sat), 128'(0));
    check("rst_state_next", 128'(state_next), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Q8.24 basics: 1+0.5*2=2, 1+0.5*(-2)=0, -1+0.5*3=0.5
    e[0] = '{data: 32'h0200_0000, sat: 1'b0};
    e[1] = '{data: 32'h0000_0000, sat: 1'b0};
    e[2] = '{data: 32'h0080_0000, sat: 1'b0};
    issue(32'h0080_0000, {32'h0300_0000, 32'hFE00_0000, 32'h0200_0000},
          {32'hFF00_0000, 32'h0100_0000, 32'h0100_0000}, e, 5);
    // Positive clamp, exact max without clamp, negative clamp
    e[0] = '{data: 32'h7FFF_FFFF, sat: 1'b1};
    e[1] = '{data: 32'h7FFF_FFFF, sat: 1'b0};
    e[2] = '{data: 32'h8000_0000, sat: 1'b1};
    issue(32'h0100_0000, {32'h8100_0000, 32'h0000_0001, 32'h7F00_0000},
          {32'h8100_0000, 32'h7FFF_FFFE, 32'h7F00_0000}, e, 5);
    // Half-LSB products: round-half-up versus floor
`ifdef EULER_STEP_ROUND_EN
    e[0] = '{data: 32'h0000_0001, sat: 1'b0};
    e[1] = '{data: 32'h0000_0000, sat: 1'b0};
`else
    e[0] = '{data: 32'h0000_0000, sat: 1'b0};
    e[1] = '{data: 32'hFFFF_FFFF, sat: 1'b0};
`endif
    e[2] = '{data: 32'h0000_0000, sat: 1'b0};
    issue(32'h0000_0001, {32'h0040_0000, 32'hFF80_0000, 32'h0080_0000}, 96'h0, e, 5);
    idle(1);
    wait_drain(50);

    // Reset with three samples in flight discards them
    for (int i = 0; i < 3; i++)
      issue_model(32'h0100_0000, {3{32'(i * 4096 + 7)}}, {3{32'(i << 20)}}, 5);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 128'(out_valid), 128'(0));
    check("midrst_busy", 128'(busy), 128'(0));
    idle(8);
    issue_model(32'h0040_0000, {32'h0123_4567, 32'hF00D_0000, 32'h0200_0000},
                {32'h0000_1000, 32'h0100_0000, 32'hFFF0_0000}, 5);
    idle(1);
    wait_drain(50);

    // Delay 200 across pointer wrap; the change to 10 waits for drain
    @(posedge clk);
    #1;
    dly = 8'd200;
    idle(3);
    for (int i = 0; i < 300; i++) begin
      if (i == 150) dly = 8'd10;
      for (int k = 0; k < int'(NCH); k++) begin
        d[k*32 +: 32] = 32'((i + 1) * (k + 1) * 4096);
        s[k*32 +: 32] = 32'(i * 65536 + k);
      end
      issue_model(32'h0100_0000, d, s, 205);
    end
    idle(1);
    wait_drain(600);
    idle(2);
    issue_model(32'h0080_0000, {3{32'h0400_0000}}, {3{32'h0000_0010}}, 15);
    idle(1);
    wait_drain(100);

    // Continuous stream, no delay
    @(posedge clk);
    #1;
    dly = 8'd0;
    idle(3);
    for (int i = 0; i < 1000; i++) begin
      t = $urandom;
      if ((i % 2) == 1) t = 32'($signed(t) >>> 8);
      d = {$urandom, $urandom, $urandom};
      s = {$urandom, $urandom, $urandom};
      issue_model(t, d, s, 5);
    end
    idle(1);
    wait_drain(100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
